// File: rtl/dff_mem_burst.sv
// dff_mem_burst: flip-flop scratch memory with a command port and valid/ready data streams.
//
// Commands (cmd_op_i): 00 READ burst, 01 WRITE burst, 10 CLEAR (zero every word), 11 rejected.
// A burst is cmd_len_i+1 beats starting at cmd_addr_i; addresses wrap modulo DEPTH.
// With RESET_CLEAR=1 a CLEAR runs automatically when reset is released.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   ena_i        global enable; low freezes all state and blocks every handshake
//   cmd_valid_i  command present          cmd_ready_o  command accepted (IDLE only)
//   cmd_op_i     command opcode           cmd_addr_i   start address
//   cmd_len_i    beats minus one
//   wr_data_i    write beat data          wr_valid_i   write beat present
//   wr_ready_o   write beat taken (WRITE state only)
//   rd_data_o    registered read data     rd_valid_o   read beat present
//   rd_ready_i   read beat consumed
//   busy_o       FSM not idle             err_o        one-cycle pulse on a rejected command
module dff_mem_burst #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned LEN_W       = 4,
    parameter bit          RESET_CLEAR = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ena_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                cmd_fire;
    logic                cmd_bad;
    logic                wr_fire;
    logic                rd_fire;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;

    // Wrap at DEPTH-1 rather than at 2^ADDR_W so non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LastAddr) ? '0 : a + ADDR_W'(1);
    endfunction

    // Output process.
    always_comb begin
        cmd_ready_o = ena_i & ~rst_i & (state_q == StIdle);
        wr_ready_o  = ena_i & ~rst_i & (state_q == StWrite);
        busy_o      = (state_q != StIdle);
        rd_data_o   = rd_data_q;
        rd_valid_o  = rd_valid_q;
        err_o       = err_q;
    end

    assign cmd_fire = cmd_valid_i & cmd_ready_o;
    assign cmd_bad  = (cmd_op_i == 2'b11) | (32'(cmd_addr_i) >= DEPTH);
    assign wr_fire  = wr_valid_i & wr_ready_o;
    assign rd_fire  = rd_valid_q & rd_ready_i & ena_i & ~rst_i;

    // Next-state process.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd_op_i)
                            2'b00: begin
                                // First word is fetched on the accept edge, so rd_valid
                                // rises one cycle after the command handshake.
                                state_d    = StRead;
                                rd_valid_d = 1'b1;
                                rd_data_d  = mem_q[IdxW'(cmd_addr_i)];
                                addr_d     = next_addr(cmd_addr_i);
                                remain_d   = cmd_len_i;
                            end
                            2'b01: begin
                                state_d  = StWrite;
                                addr_d   = cmd_addr_i;
                                remain_d = cmd_len_i;
                            end
                            default: begin
                                state_d = StClear;
                                addr_d  = '0;
                            end
                        endcase
                    end
                end
            end
            StWrite: begin
                if (wr_fire) begin
                    addr_d = next_addr(addr_q);
                    if (remain_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        remain_d = remain_q - LEN_W'(1);
                    end
                end
            end
            StRead: begin
                if (rd_fire) begin
                    if (remain_q == '0) begin
                        rd_valid_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        rd_data_d = mem_q[IdxW'(addr_q)];
                        addr_d    = next_addr(addr_q);
                        remain_d  = remain_q - LEN_W'(1);
                    end
                end
            end
            StClear: begin
                if (ena_i) begin
                    addr_d = next_addr(addr_q);
                    if (addr_q == LastAddr) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RESET_CLEAR ? StClear : StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset; CLEAR provides the known-zero state instead.
    assign mem_we    = wr_fire | ((state_q == StClear) & ena_i & ~rst_i);
    assign mem_wdata = (state_q == StClear) ? '0 : wr_data_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[IdxW'(addr_q)] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dff_mem_burst.sv
// Testbench for dff_mem_burst: two instances (DEPTH 16 and DEPTH 12) driven by directed and
// random transactions. Expected read beats are queued from a plain array model and checked by
// per-instance monitors whenever a read handshake occurs.
module tb_dff_mem_burst;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = 4;
    localparam logic [1:0]  OpRead  = 2'b00;
    localparam logic [1:0]  OpWrite = 2'b01;
    localparam logic [1:0]  OpClear = 2'b10;
    localparam logic [1:0]  OpRsvd  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [2];
    logic          ena       [2];
    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic [1:0]    cmd_op    [2];
    logic [AW-1:0] cmd_addr  [2];
    logic [LW-1:0] cmd_len   [2];
    logic [DW-1:0] wr_data   [2];
    logic          wr_valid  [2];
    logic          wr_ready  [2];
    logic [DW-1:0] rd_data   [2];
    logic          rd_valid  [2];
    logic          rd_ready  [2];
    logic          busy      [2];
    logic          err       [2];

    dff_mem_burst #(.DATA_W(DW), .DEPTH(16), .ADDR_W(AW), .LEN_W(LW), .RESET_CLEAR(1'b1)) u_dut16 (
        .clk_i(clk), .rst_i(rst[0]), .ena_i(ena[0]),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_op_i(cmd_op[0]),
        .cmd_addr_i(cmd_addr[0]), .cmd_len_i(cmd_len[0]),
        .wr_data_i(wr_data[0]), .wr_valid_i(wr_valid[0]), .wr_ready_o(wr_ready[0]),
        .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]), .rd_ready_i(rd_ready[0]),
        .busy_o(busy[0]), .err_o(err[0])
    );

    dff_mem_burst #(.DATA_W(DW), .DEPTH(12), .ADDR_W(AW), .LEN_W(LW), .RESET_CLEAR(1'b1)) u_dut12 (
        .clk_i(clk), .rst_i(rst[1]), .ena_i(ena[1]),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_op_i(cmd_op[1]),
        .cmd_addr_i(cmd_addr[1]), .cmd_len_i(cmd_len[1]),
        .wr_data_i(wr_data[1]), .wr_valid_i(wr_valid[1]), .wr_ready_o(wr_ready[1]),
        .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]), .rd_ready_i(rd_ready[1]),
        .busy_o(busy[1]), .err_o(err[1])
    );

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   depth [2] = '{16, 12};
    logic [DW-1:0] mm [2][16];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] wbuf [16];
    int            ena_gap_beat = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int s, input logic [DW-1:0] v);
        if (s == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    task automatic monitor_step(input int s, inout logic stalled, inout logic [DW-1:0] held);
        logic [DW-1:0] e;
        if (rst[s]) begin
            stalled = 1'b0;
            return;
        end
        if (stalled && rd_valid[s]) check("rd_stall_hold", 32'(rd_data[s]), 32'(held));
        stalled = rd_valid[s] && !rd_ready[s];
        held    = rd_data[s];
        if (rd_valid[s] && rd_ready[s] && ena[s]) begin
            if (qsize(s) == 0) begin
                check("rd_extra_beat", 32'(rd_valid[s]), 32'd0);
            end else begin
                e = (s == 0) ? q0.pop_front() : q1.pop_front();
                check("rd_data", 32'(rd_data[s]), 32'(e));
            end
        end
    endtask

    logic          stalled0 = 1'b0, stalled1 = 1'b0;
    logic [DW-1:0] held0 = '0, held1 = '0;
    always @(negedge clk) monitor_step(0, stalled0, held0);
    always @(negedge clk) monitor_step(1, stalled1, held1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int s, input logic [1:0] op, input logic [AW-1:0] a,
                            input logic [LW-1:0] l);
        int n;
        n = 0;
        cmd_valid[s] = 1'b1;
        cmd_op[s]    = op;
        cmd_addr[s]  = a;
        cmd_len[s]   = l;
        @(negedge clk);
        while (!cmd_ready[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready[s]), 32'd1);
        tick();
        cmd_valid[s] = 1'b0;
    endtask

    task automatic do_reset(input int s);
        int n;
        rst[s] = 1'b1; ena[s] = 1'b1;
        cmd_valid[s] = 1'b0; wr_valid[s] = 1'b0; rd_ready[s] = 1'b0;
        tick();
        if (s == 0) q0.delete();
        else q1.delete();
        check("rst_rd_valid", 32'(rd_valid[s]), 32'd0);
        check("rst_rd_data", 32'(rd_data[s]), 32'd0);
        check("rst_err", 32'(err[s]), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready[s]), 32'd0);
        check("rst_wr_ready", 32'(wr_ready[s]), 32'd0);
        check("rst_busy", 32'(busy[s]), 32'd1);
        tick();
        rst[s] = 1'b0;
        n = 0;
        while (busy[s] && n < 100) begin
            tick();
            n++;
        end
        check("rst_clear_cycles", 32'(n), 32'(depth[s]));
        for (int i = 0; i < 16; i++) mm[s][i] = '0;
    endtask

    task automatic run_write(input int s, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int cur;
        int n;
        cur = int'(a);
        for (int i = 0; i <= int'(l); i++) begin
            wr_valid[s] = 1'b1;
            if (i == ena_gap_beat) begin
                wr_data[s] = ~wbuf[i];
                ena[s] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("wr_ready_ena_low", 32'(wr_ready[s]), 32'd0);
                    check("busy_ena_low", 32'(busy[s]), 32'd1);
                    tick();
                end
                ena[s] = 1'b1;
            end
            wr_data[s] = wbuf[i];
            n = 0;
            @(negedge clk);
            while (!wr_ready[s] && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("wr_accept", 32'(wr_ready[s]), 32'd1);
            tick();
            mm[s][cur] = wbuf[i];
            cur = (cur + 1) % int'(depth[s]);
            wr_valid[s] = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        check("write_done_idle", 32'(busy[s]), 32'd0);
    endtask

    // mode 0: rd_ready always high; 1: pattern 1,0,0 repeating; 2: random.
    task automatic run_read(input int s, input int mode, input logic [LW-1:0] l);
        int cyc;
        cyc = 0;
        while (qsize(s) != 0 && cyc < 400) begin
            case (mode)
                0:       rd_ready[s] = 1'b1;
                1:       rd_ready[s] = (cyc % 3 == 0);
                default: rd_ready[s] = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        rd_ready[s] = 1'b0;
        check("rd_drained", 32'(qsize(s)), 32'd0);
        check("rd_done_busy", 32'(busy[s]), 32'd0);
        check("rd_done_valid", 32'(rd_valid[s]), 32'd0);
        if (mode == 0) check("rd_back_to_back", 32'(cyc), 32'(int'(l) + 1));
    endtask

    task automatic do_txn(input int s, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [LW-1:0] l, input int mode);
        bit bad;
        int n;
        bad = (op == OpRsvd) || (int'(a) >= int'(depth[s]));
        send_cmd(s, op, a, l);
        if (bad) begin
            check("err_pulse", 32'(err[s]), 32'd1);
            check("err_stays_idle", 32'(busy[s]), 32'd0);
            tick();
            check("err_one_cycle", 32'(err[s]), 32'd0);
        end else begin
            check("err_quiet", 32'(err[s]), 32'd0);
            check("busy_after_accept", 32'(busy[s]), 32'd1);
            case (op)
                OpRead: begin
                    for (int i = 0; i <= int'(l); i++)
                        push_exp(s, mm[s][(int'(a) + i) % int'(depth[s])]);
                    run_read(s, mode, l);
                end
                OpWrite: run_write(s, a, l);
                default: begin
                    n = 0;
                    while (busy[s] && n < 100) begin
                        tick();
                        n++;
                    end
                    check("clear_cycles", 32'(n), 32'(depth[s]));
                    for (int i = 0; i < 16; i++) mm[s][i] = '0;
                end
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            s;
        int            r;
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; ena[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_op[i] = '0;
            cmd_addr[i] = '0; cmd_len[i] = '0; wr_data[i] = '0; wr_valid[i] = 1'b0;
            rd_ready[i] = 1'b0;
        end
        do_reset(0);
        do_reset(1);

        // Cleared memory reads back as zero.
        do_txn(0, OpRead, 4'd0, 4'd15, 0);

        // Short burst write/readback.
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hFF;
        do_txn(0, OpWrite, 4'd3, 4'd2, 0);
        do_txn(0, OpRead, 4'd3, 4'd2, 0);

        // Wrap at DEPTH on both instances.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        do_txn(0, OpWrite, 4'd14, 4'd3, 0);
        do_txn(0, OpRead, 4'd14, 4'd3, 2);
        do_txn(0, OpRead, 4'd0, 4'd1, 0);
        do_txn(1, OpWrite, 4'd11, 4'd3, 0);
        do_txn(1, OpRead, 4'd11, 4'd3, 0);
        do_txn(1, OpRead, 4'd0, 4'd11, 0);

        // Stalled reads.
        do_txn(0, OpRead, 4'd3, 4'd3, 1);

        // Rejected commands leave memory untouched.
        do_txn(0, OpRsvd, 4'd5, 4'd0, 0);
        do_txn(1, OpRead, 4'd12, 4'd0, 0);
        do_txn(1, OpWrite, 4'd13, 4'd2, 0);
        do_txn(1, OpRead, 4'd0, 4'd15, 0);

        // Enable drop mid-write.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'h30 + i);
        ena_gap_beat = 1;
        do_txn(0, OpWrite, 4'd6, 4'd3, 0);
        ena_gap_beat = -1;
        do_txn(0, OpRead, 4'd5, 4'd5, 0);

        // Reset mid-read restarts the clear.
        send_cmd(0, OpRead, 4'd2, 4'd15);
        for (int i = 0; i < 16; i++) push_exp(0, mm[0][(2 + i) % 16]);
        rd_ready[0] = 1'b1;
        repeat (3) tick();
        do_reset(0);
        do_txn(0, OpRead, 4'd0, 4'd15, 0);

        // Explicit CLEAR command.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'(8'hC0 + i);
        do_txn(0, OpWrite, 4'd0, 4'd15, 0);
        do_txn(0, OpClear, 4'd7, 4'd3, 0);
        do_txn(0, OpRead, 4'd8, 4'd15, 2);

        for (int t = 0; t < 80; t++) begin
            s  = (t % 3 == 2) ? 1 : 0;
            r  = int'($urandom_range(0, 19));
            op = (r < 8) ? OpRead : (r < 16) ? OpWrite : (r < 18) ? OpRsvd : OpClear;
            a  = AW'($urandom_range(0, 15));
            l  = LW'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_txn(s, op, a, l, int'($urandom_range(0, 2)));
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
